output_display: RTL and testbench

- Downstream consumer of the CPU's `output_port[15:0]` and `PC_below8bit[7:0]`.
- Captures the CPU output word and drives a time-multiplexed 4-digit hex 7-segment display from it.
- Mirrors the PC onto 8 LEDs.
- Flashes an update LED whenever the displayed word changes, so the board shows WWD and register_selection activity.

---
 rtl/output_display_pkg.sv | 17 +
 rtl/output_display_hex_to_seg7.sv | 11 +
 rtl/output_display.sv | 157 +++++++++++++++
 tb/tb_output_display.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/output_display_pkg.sv
// Shared constants for the CPU output display: segment codes and flasher states.
package output_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} codes for hex digits 0..F
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_e;

endpackage

// File: rtl/output_display_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg7
    import output_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/output_display.sv
// Captures the CPU output word onto a scanned 4-digit hex display, mirrors the
// PC low byte onto LEDs and flashes an LED whenever the captured word changes.
module output_display
    import output_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned FLASH_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        reset_cpu,
    input  logic [15:0] output_port,
    input  logic [7:0]  PC_below8bit,
    input  logic        freeze,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [7:0]  pc_led,
    output logic        update_led
);

    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES - 1);

    logic [15:0]        disp_q;
    logic [7:0]         pc_led_q;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         digit_q, digit_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [3:0]         an_q, an_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    flash_state_e       state_q, state_d;

    logic               tick;
    logic               change;
    logic [3:0]         nibble;
    logic [6:0]         hex_seg;
    logic [3:0]         lz;

    // Capture and PC mirror
    always_ff @(posedge clk) begin
        if (reset_cpu) begin
            disp_q   <= '0;
            pc_led_q <= '0;
        end else begin
            if (!freeze) begin
                disp_q <= output_port;
            end
            pc_led_q <= PC_below8bit;
        end
    end

    // Digit scan
    assign tick = (scan_cnt_q == SCAN_LAST);

    always_comb begin
        scan_cnt_d = tick ? '0 : scan_cnt_q + 1'b1;
        digit_d    = tick ? digit_q + 2'd1 : digit_q;
    end

    always_ff @(posedge clk) begin
        if (reset_cpu) begin
            scan_cnt_q <= '0;
            digit_q    <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
        end
    end

    assign nibble = disp_q[{digit_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nibble),
        .seg_o    (hex_seg)
    );

    // lz[k]: nibble k and every higher nibble are zero; digit 0 never blanks
    always_comb begin
        lz    = '0;
        lz[3] = (disp_q[15:12] == 4'h0);
        lz[2] = lz[3] && (disp_q[11:8] == 4'h0);
        lz[1] = lz[2] && (disp_q[7:4]  == 4'h0);
    end

    always_comb begin
        seg_d = (blank_lz && lz[digit_q]) ? SEG_BLANK : hex_seg;
        an_d  = ~(4'b0001 << digit_q);
        dp_d  = !((digit_q == 2'd0) && freeze);
    end

    always_ff @(posedge clk) begin
        if (reset_cpu) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= 4'hF;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    // Update flasher
    assign change = !freeze && (output_port != disp_q);

    always_ff @(posedge clk) begin
        if (reset_cpu) begin
            state_q     <= IDLE;
            flash_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        case (state_q)
            IDLE: begin
                if (change) begin
                    state_d     = FLASH;
                    flash_cnt_d = FLASH_LOAD;
                end
            end
            FLASH: begin
                if (change) begin
                    flash_cnt_d = FLASH_LOAD;
                end else if (flash_cnt_q != '0) begin
                    flash_cnt_d = flash_cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                flash_cnt_d = '0;
            end
        endcase
    end

    // The FLASH state is itself the registered LED drive
    always_comb begin
        update_led = (state_q == FLASH);
    end

    assign seg    = seg_q;
    assign dp     = dp_q;
    assign an     = an_q;
    assign pc_led = pc_led_q;

endmodule

// File: tb/tb_output_display.sv
// Directed, table-driven bench for output_display with SCAN_DIV=4, FLASH_CYCLES=8.
module tb_output_display;

    logic        clk = 1'b0;
    logic        reset_cpu;
    logic [15:0] output_port;
    logic [7:0]  PC_below8bit;
    logic        freeze;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [7:0]  pc_led;
    logic        update_led;

    int checks = 0;
    int errors = 0;

    output_display #(
        .SCAN_DIV     (4),
        .FLASH_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset_cpu    (reset_cpu),
        .output_port  (output_port),
        .PC_below8bit (PC_below8bit),
        .freeze       (freeze),
        .blank_lz     (blank_lz),
        .seg          (seg),
        .dp           (dp),
        .an           (an),
        .pc_led       (pc_led),
        .update_led   (update_led)
    );

    always #5 clk = ~clk;

    // segs packs the expected codes as {digit3, digit2, digit1, digit0}
    typedef struct packed {
        logic [15:0] port;
        logic        lz;
        logic        frz;
        logic [27:0] segs;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges, ending on a falling edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // One reset edge, then released; next step(1) is edge E1
    task automatic apply_reset(input logic [15:0] port);
        reset_cpu   = 1'b1;
        output_port = port;
        step(1);
        reset_cpu = 1'b0;
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        logic [3:0] exp_an;
        logic       exp_dp;
        freeze   = v.frz;
        blank_lz = v.lz;
        apply_reset(v.port);
        step(2);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) step(4);
            exp_an = ~(4'b0001 << d);
            exp_dp = !((d == 0) && v.frz);
            chk($sformatf("vec%0d_d%0d_seg", idx, d), 32'(seg), 32'(v.segs[d*7 +: 7]));
            chk($sformatf("vec%0d_d%0d_an", idx, d), 32'(an), 32'(exp_an));
            chk($sformatf("vec%0d_d%0d_dp", idx, d), 32'(dp), 32'(exp_dp));
        end
    endtask

    initial begin
        logic [6:0] exp_seg;
        logic [6:0] s0204 [4];
        logic [3:0] exp_an;
        int         dg;

        reset_cpu    = 1'b1;
        output_port  = '0;
        PC_below8bit = '0;
        freeze       = 1'b0;
        blank_lz     = 1'b0;

        vecs[0] = '{16'h0204, 1'b0, 1'b0, {7'h40, 7'h24, 7'h40, 7'h19}};
        vecs[1] = '{16'h0004, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h19}};
        vecs[2] = '{16'h0000, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h0000, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{16'h89AB, 1'b0, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03}};
        vecs[5] = '{16'hCDEF, 1'b1, 1'b0, {7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[6] = '{16'h0567, 1'b1, 1'b0, {7'h7F, 7'h12, 7'h02, 7'h78}};
        vecs[7] = '{16'h1000, 1'b1, 1'b0, {7'h79, 7'h40, 7'h40, 7'h40}};
        vecs[8] = '{16'h0030, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h30, 7'h40}};
        vecs[9] = '{16'hFFFF, 1'b0, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}};

        @(negedge clk);

        // Reset held two cycles, then capture of 16'h1234
        reset_cpu    = 1'b1;
        output_port  = 16'h1234;
        PC_below8bit = 8'h5A;
        for (int c = 0; c < 2; c++) begin
            step(1);
            chk($sformatf("rst%0d_seg", c), 32'(seg), 32'h7F);
            chk($sformatf("rst%0d_an", c), 32'(an), 32'hF);
            chk($sformatf("rst%0d_dp", c), 32'(dp), 32'h1);
            chk($sformatf("rst%0d_pc", c), 32'(pc_led), 32'h0);
            chk($sformatf("rst%0d_led", c), 32'(update_led), 32'h0);
        end
        reset_cpu = 1'b0;
        step(1);
        chk("rel_led", 32'(update_led), 32'h1);
        chk("rel_pc", 32'(pc_led), 32'h5A);
        step(1);
        chk("rel_seg_1234", 32'(seg), 32'h19);
        chk("rel_an", 32'(an), 32'hE);

        for (int i = 0; i < 10; i++) begin
            run_vector(vecs[i], i);
        end
        freeze   = 1'b0;
        blank_lz = 1'b0;

        // Scan order and dwell: display at edge n shows digit ((n-1)/4)%4
        s0204[0] = 7'h19; s0204[1] = 7'h40; s0204[2] = 7'h24; s0204[3] = 7'h40;
        apply_reset(16'h0204);
        for (int n = 1; n <= 20; n++) begin
            step(1);
            dg      = ((n - 1) / 4) % 4;
            exp_an  = ~(4'b0001 << dg);
            exp_seg = (n == 1) ? 7'h40 : s0204[dg];
            chk($sformatf("scan_e%0d_an", n), 32'(an), 32'(exp_an));
            chk($sformatf("scan_e%0d_seg", n), 32'(seg), 32'(exp_seg));
        end

        // Flash, then retrigger at the fifth cycle
        apply_reset(16'h0100);
        step(12);
        chk("flash_idle", 32'(update_led), 32'h0);
        output_port = 16'h00FC;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk($sformatf("flash_on%0d", k), 32'(update_led), 32'h1);
        end
        step(1);
        chk("flash_off", 32'(update_led), 32'h0);
        output_port = 16'h0001;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk($sformatf("retrig_a%0d", k), 32'(update_led), 32'h1);
        end
        output_port = 16'h0002;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk($sformatf("retrig_b%0d", k), 32'(update_led), 32'h1);
        end
        step(1);
        chk("retrig_off", 32'(update_led), 32'h0);

        // Freeze holds 0300 while the port moves to 0304
        apply_reset(16'h0300);
        step(16);
        freeze      = 1'b1;
        output_port = 16'h0304;
        for (int n = 17; n <= 28; n++) begin
            step(1);
            dg      = ((n - 1) / 4) % 4;
            exp_seg = (dg == 2) ? 7'h30 : 7'h40;
            chk($sformatf("frz_e%0d_seg", n), 32'(seg), 32'(exp_seg));
            chk($sformatf("frz_e%0d_dp", n), 32'(dp), (dg == 0) ? 32'h0 : 32'h1);
            chk($sformatf("frz_e%0d_led", n), 32'(update_led), 32'h0);
        end
        freeze = 1'b0;
        step(1);
        chk("unfrz_led", 32'(update_led), 32'h1);
        chk("unfrz_seg_d3", 32'(seg), 32'h40);
        step(4);
        chk("unfrz_seg_d0", 32'(seg), 32'h19);
        chk("unfrz_dp", 32'(dp), 32'h1);
        chk("unfrz_an", 32'(an), 32'hE);

        // PC mirror, including while frozen
        PC_below8bit = 8'd21;
        step(1);
        chk("pc_21", 32'(pc_led), 32'd21);
        freeze       = 1'b1;
        PC_below8bit = 8'hA5;
        step(1);
        chk("pc_frozen", 32'(pc_led), 32'hA5);
        freeze = 1'b0;

        // Reset while digit 2 is scanning and the flasher is active
        apply_reset(16'h0F00);
        step(8);
        output_port = 16'h0F01;
        step(1);
        chk("mid_led", 32'(update_led), 32'h1);
        chk("mid_an_d2", 32'(an), 32'hB);
        reset_cpu = 1'b1;
        step(1);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_dp", 32'(dp), 32'h1);
        chk("midrst_led", 32'(update_led), 32'h0);
        chk("midrst_pc", 32'(pc_led), 32'h0);
        reset_cpu = 1'b0;
        step(1);
        chk("restart_an", 32'(an), 32'hE);
        chk("restart_seg", 32'(seg), 32'h40);
        chk("restart_pc", 32'(pc_led), 32'hA5);
        step(4);
        chk("restart_an_d1", 32'(an), 32'hD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
